sample_router: RTL and testbench

Parametrised N-channel sample router and successor to the fixed 4-in/4-out passthrough core. Each output selects any input and applies a per-output mode: pass, saturating invert, mute, or half-gain. Routing changes are written into a shadow table and committed atomically on a sample boundary, so no frame ever mixes old and new routing. The router sits between the codec sample interface and the DSP cores, in the `clk` domain, with `sample_clk` synchronised internally.

---
 rtl/sample_router.sv | 144 ++++++++++++++
 tb/tb_sample_router.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_router.sv
// rtl/sample_router.sv - N-channel sample router with shadow routing table and frame-atomic commit
//
// Purpose: each output picks any input and applies pass / saturating invert /
// mute / half-gain. Routing edits land in a shadow table and are copied into
// the active table on the first frame strobe after a commit request.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   sample_clk        frame clock (async), rising edge starts a frame
//   sample_in[N*W]    input samples, channel i at [i*W +: W]
//   jack[N]           per-input plugged flag
//   sample_out[N*W]   registered output samples, same packing
//   frame_tick        one-cycle pulse when sample_out updates
//   cfg_valid/cfg_ready, cfg_out, cfg_src, cfg_mode   shadow-table write
//   cfg_commit        request to apply the shadow table at the next strobe
module sample_router #(
  parameter int W              = 16,
  parameter int N              = 4,
  parameter int SEL_W          = $clog2(N),
  parameter bit ZERO_UNPLUGGED = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_clk,
  input  logic [N*W-1:0]   sample_in,
  output logic [N*W-1:0]   sample_out,
  input  logic [N-1:0]     jack,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [SEL_W-1:0] cfg_out,
  input  logic [SEL_W-1:0] cfg_src,
  input  logic [1:0]       cfg_mode,
  input  logic             cfg_commit,
  output logic             frame_tick
);

  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_INVERT = 2'd1;
  localparam logic [1:0] MODE_MUTE   = 2'd2;

  localparam logic signed [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};

  logic s1_q, s2_q, s3_q;
  logic strobe;

  logic pending_q, pending_d;

  logic [SEL_W-1:0] act_src_q  [N];
  logic [SEL_W-1:0] act_src_d  [N];
  logic [1:0]       act_mode_q [N];
  logic [1:0]       act_mode_d [N];
  logic [SEL_W-1:0] shd_src_q  [N];
  logic [SEL_W-1:0] shd_src_d  [N];
  logic [1:0]       shd_mode_q [N];
  logic [1:0]       shd_mode_d [N];

  logic [N*W-1:0] sample_out_q, sample_out_d;
  logic           frame_tick_q, frame_tick_d;

  logic             cfg_wr, cfg_cm, apply;
  logic signed [W-1:0] x, y;

  // s3 only remembers the previous s2 so a held-high sample_clk strobes once.
  assign strobe = s2_q & ~s3_q;

  assign cfg_ready  = ~pending_q;
  assign sample_out = sample_out_q;
  assign frame_tick = frame_tick_q;

  always_comb begin
    cfg_wr = cfg_valid  & ~pending_q;
    cfg_cm = cfg_commit & ~pending_q;
    // Only a commit already pending before this strobe is applied now.
    apply  = strobe & pending_q;

    for (int i = 0; i < N; i++) begin
      shd_src_d[i]  = shd_src_q[i];
      shd_mode_d[i] = shd_mode_q[i];
      act_src_d[i]  = apply ? shd_src_q[i]  : act_src_q[i];
      act_mode_d[i] = apply ? shd_mode_q[i] : act_mode_q[i];
    end

    // Writes to an out-of-range output are accepted but dropped.
    if (cfg_wr && (int'(cfg_out) < N)) begin
      shd_src_d[cfg_out]  = cfg_src;
      shd_mode_d[cfg_out] = cfg_mode;
    end

    if (apply)       pending_d = 1'b0;
    else if (cfg_cm) pending_d = 1'b1;
    else             pending_d = pending_q;

    frame_tick_d = strobe;
    sample_out_d = sample_out_q;
    x = '0;
    y = '0;
    for (int o = 0; o < N; o++) begin
      x = '0;
      if (int'(act_src_d[o]) < N) begin
        x = sample_in[int'(act_src_d[o])*W +: W];
        if (ZERO_UNPLUGGED && !jack[act_src_d[o]]) x = '0;
      end
      case (act_mode_d[o])
        MODE_PASS:   y = x;
        MODE_INVERT: y = (x == MIN_VAL) ? MAX_VAL : -x;
        MODE_MUTE:   y = '0;
        default:     y = x >>> 1;
      endcase
      if (strobe) sample_out_d[o*W +: W] = y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      pending_q    <= 1'b0;
      sample_out_q <= '0;
      frame_tick_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        act_src_q[i]  <= SEL_W'(i);
        act_mode_q[i] <= MODE_PASS;
        shd_src_q[i]  <= SEL_W'(i);
        shd_mode_q[i] <= MODE_PASS;
      end
    end else begin
      s1_q         <= sample_clk;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      pending_q    <= pending_d;
      sample_out_q <= sample_out_d;
      frame_tick_q <= frame_tick_d;
      for (int i = 0; i < N; i++) begin
        act_src_q[i]  <= act_src_d[i];
        act_mode_q[i] <= act_mode_d[i];
        shd_src_q[i]  <= shd_src_d[i];
        shd_mode_q[i] <= shd_mode_d[i];
      end
    end
  end

endmodule

// File: tb/tb_sample_router.sv
// tb/tb_sample_router.sv - self-checking bench for sample_router
module tb_sample_router;

  localparam int W = 16;
  localparam int N = 4;
  localparam int SEL_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             sample_clk;
  logic [N*W-1:0]   sample_in;
  logic [N*W-1:0]   out_z, out_p;
  logic [N-1:0]     jack;
  logic             cfg_valid, cfg_commit;
  logic             rdy_z, rdy_p, tick_z, tick_p;
  logic [SEL_W-1:0] cfg_out, cfg_src;
  logic [1:0]       cfg_mode;

  int in_v [N];
  int n_cmp = 0;
  int n_bad = 0;
  int tick_cnt = 0;
  bit chk_en = 1'b0;

  // Spec-level model state
  int m_src [N], m_mode [N], s_src [N], s_mode [N];
  int exp_z [N], exp_p [N];
  bit m_pend, exp_tick, prev_sc;
  int age;

  always #5 clk = ~clk;

  always_comb begin
    sample_in = '0;
    for (int i = 0; i < N; i++) sample_in[i*W +: W] = W'(in_v[i]);
  end

  sample_router #(.W(W), .N(N), .SEL_W(SEL_W), .ZERO_UNPLUGGED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .sample_clk(sample_clk), .sample_in(sample_in),
    .sample_out(out_z), .jack(jack), .cfg_valid(cfg_valid), .cfg_ready(rdy_z),
    .cfg_out(cfg_out), .cfg_src(cfg_src), .cfg_mode(cfg_mode),
    .cfg_commit(cfg_commit), .frame_tick(tick_z));

  sample_router #(.W(W), .N(N), .SEL_W(SEL_W), .ZERO_UNPLUGGED(1'b0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .sample_clk(sample_clk), .sample_in(sample_in),
    .sample_out(out_p), .jack(jack), .cfg_valid(cfg_valid), .cfg_ready(rdy_p),
    .cfg_out(cfg_out), .cfg_src(cfg_src), .cfg_mode(cfg_mode),
    .cfg_commit(cfg_commit), .frame_tick(tick_p));

  function automatic int get(input logic [N*W-1:0] v, input int i);
    logic signed [W-1:0] s;
    s = v[i*W +: W];
    return int'(s);
  endfunction

  function automatic int calc(input int src, input int mode, input int zu);
    int v;
    v = (src < N) ? in_v[src] : 0;
    if (src < N && zu != 0 && !jack[src]) v = 0;
    case (mode)
      0: return v;
      1: return (v == -(2 ** (W - 1))) ? (2 ** (W - 1)) - 1 : -v;
      2: return 0;
      default: return (v < 0 && (v % 2) != 0) ? (v - 1) / 2 : v / 2;
    endcase
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: frame lands on the second clk edge after the edge that first sees sample_clk high.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < N; i++) begin
          m_src[i] = i; m_mode[i] = 0; s_src[i] = i; s_mode[i] = 0;
          exp_z[i] = 0; exp_p[i] = 0;
        end
        m_pend = 1'b0; exp_tick = 1'b0; prev_sc = 1'b0; age = 3;
      end else begin
        bit rdy;
        rdy = !m_pend;
        if (sample_clk && !prev_sc) age = 0;
        else if (age < 3) age++;
        prev_sc = sample_clk;
        exp_tick = (age == 2);
        if (exp_tick) begin
          if (m_pend) begin
            for (int i = 0; i < N; i++) begin m_src[i] = s_src[i]; m_mode[i] = s_mode[i]; end
            m_pend = 1'b0;
          end
          for (int o = 0; o < N; o++) begin
            exp_z[o] = calc(m_src[o], m_mode[o], 1);
            exp_p[o] = calc(m_src[o], m_mode[o], 0);
          end
        end
        if (rdy) begin
          if (cfg_valid && int'(cfg_out) < N) begin
            s_src[cfg_out] = int'(cfg_src); s_mode[cfg_out] = int'(cfg_mode);
          end
          if (cfg_commit) m_pend = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (tick_z) tick_cnt++;
    if (chk_en) begin
      for (int o = 0; o < N; o++) begin
        cmp($sformatf("model_out_zu1[%0d]", o), get(out_z, o), exp_z[o]);
        cmp($sformatf("model_out_zu0[%0d]", o), get(out_p, o), exp_p[o]);
      end
      cmp("model_tick_zu1", int'(tick_z), int'(exp_tick));
      cmp("model_tick_zu0", int'(tick_p), int'(exp_tick));
      cmp("model_ready_zu1", int'(rdy_z), int'(!m_pend));
      cmp("model_ready_zu0", int'(rdy_p), int'(!m_pend));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic frame();
    sample_clk = 1'b1;
    repeat (4) tick();
    sample_clk = 1'b0;
    repeat (4) tick();
  endtask

  task automatic wr(input int o, input int s, input int m);
    cfg_valid = 1'b1;
    cfg_out = SEL_W'(o); cfg_src = SEL_W'(s); cfg_mode = 2'(m);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic cm();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  initial begin
    int t0;
    rst_n = 1'b0; sample_clk = 1'b0; jack = '0;
    cfg_valid = 1'b0; cfg_commit = 1'b0; cfg_out = '0; cfg_src = '0; cfg_mode = '0;
    for (int i = 0; i < N; i++) in_v[i] = 0;
    repeat (3) tick();
    cmp("reset_out", get(out_z, 0), 0);
    cmp("reset_tick", int'(tick_z), 0);
    cmp("reset_ready", int'(rdy_z), 1);
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick();

    // Passthrough frame
    jack = 4'hF;
    in_v[0] = 100; in_v[1] = -200; in_v[2] = 300; in_v[3] = -400;
    t0 = tick_cnt;
    frame();
    cmp("pass_out0", get(out_z, 0), 100);
    cmp("pass_out1", get(out_z, 1), -200);
    cmp("pass_out2", get(out_z, 2), 300);
    cmp("pass_out3", get(out_z, 3), -400);
    cmp("pass_tick_count", tick_cnt - t0, 1);

    // Commit without a frame: held until the next frame
    wr(0, 3, 1);
    cm();
    tick();
    cmp("pend_ready", int'(rdy_z), 0);
    cmp("pend_out0_unchanged", get(out_z, 0), 100);
    frame();
    cmp("commit_out0", get(out_z, 0), 400);
    cmp("commit_ready", int'(rdy_z), 1);

    // Saturating invert, half, mute
    in_v[3] = -32768;
    frame();
    cmp("invert_sat", get(out_z, 0), 32767);
    wr(1, 1, 3); wr(2, 2, 3); wr(3, 3, 2);
    cm();
    in_v[1] = -3; in_v[2] = 5;
    frame();
    cmp("half_neg3", get(out_z, 1), -2);
    cmp("half_5", get(out_z, 2), 2);
    cmp("mute", get(out_z, 3), 0);

    // Unplugged source
    wr(1, 1, 0);
    cm();
    jack = 4'b1101; in_v[1] = 1234;
    frame();
    cmp("unplug_zu1", get(out_z, 1), 0);
    cmp("unplug_zu0", get(out_p, 1), 1234);

    // Commit on the strobe cycle is deferred; writes while pending are dropped
    wr(2, 0, 0);
    sample_clk = 1'b1;
    tick();
    tick();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    cmp("strobe_commit_ready", int'(rdy_z), 0);
    cmp("strobe_commit_out2_old", get(out_z, 2), 2);
    wr(3, 0, 0);
    repeat (2) tick();
    sample_clk = 1'b0;
    repeat (4) tick();
    frame();
    cmp("deferred_out2", get(out_z, 2), 100);
    cmp("ignored_write_out3", get(out_z, 3), 0);
    cmp("deferred_ready", int'(rdy_z), 1);

    // Reset mid-frame with a commit pending
    wr(0, 1, 2);
    cm();
    sample_clk = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    cmp("midrst_out0", get(out_z, 0), 0);
    cmp("midrst_ready", int'(rdy_z), 1);
    jack = 4'hF;
    in_v[0] = 7; in_v[1] = -8; in_v[2] = 9; in_v[3] = -10;
    rst_n = 1'b1;
    repeat (4) tick();
    sample_clk = 1'b0;
    repeat (4) tick();
    frame();
    cmp("post_rst_out0", get(out_z, 0), 7);
    cmp("post_rst_out1", get(out_z, 1), -8);
    cmp("post_rst_out2", get(out_z, 2), 9);
    cmp("post_rst_out3", get(out_z, 3), -10);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
